fetch_unit: RTL and testbench

- Instruction-fetch stage of the 16-bit pipelined core; sits directly upstream of the control/decode stage and drives its `inst` input.
- Holds the PC and issues word requests to instruction memory, tolerating variable response latency.
- Buffers returned words in a small prefetch FIFO and presents one instruction per cycle with a valid flag.
- Honours decode stalls, and accepts PC redirects from jump (opcode 11) and taken conditional branch (opcode 12) resolution, discarding wrong-path fetches.

---
 rtl/core_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit pipelined core: widths, opcodes and the bubble word.
package core_pkg;

   localparam int unsigned INST_W = 16;
   localparam int unsigned OPC_W  = 4;

   localparam logic [OPC_W-1:0] OP_JUMP   = 4'd11;
   localparam logic [OPC_W-1:0] OP_BRANCH = 4'd12;
   localparam logic [OPC_W-1:0] OP_MUL    = 4'd15;

   // Instruction presented to decode when fetch has nothing valid.
   localparam logic [INST_W-1:0] INST_BUBBLE = 16'h0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface fetch_unit_if #(
   parameter int unsigned ADDR_W = 16
);
   import core_pkg::*;

   logic                 imem_req;
   logic [ADDR_W-1:0]    imem_addr;
   logic                 imem_ready;
   logic                 imem_rvalid;
   logic [INST_W-1:0]    imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instruction, pc} pairs; clear dominates push/pop, push+pop legal when full.
module fetch_fifo
   import core_pkg::*;
#(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned ADDR_W = 16,
   localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              push_i,
   input  logic [INST_W-1:0] push_inst_i,
   input  logic [ADDR_W-1:0] push_pc_i,
   input  logic              pop_i,
   output logic [INST_W-1:0] head_inst_o,
   output logic [ADDR_W-1:0] head_pc_o,
   output logic [CntW-1:0]   count_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

   logic [INST_W-1:0] inst_mem_q [DEPTH];
   logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              do_push, do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   // Pointer and occupancy next-state; a push into a full FIFO needs a simultaneous pop.
   always_comb begin
      do_pop   = pop_i && (count_q != '0);
      do_push  = push_i && ((count_q != DEPTH[CntW-1:0]) || do_pop);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         count_d = count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   // Control state, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are only observed through a valid count.
   always_ff @(posedge clk) begin
      if (do_push && !clear_i) begin
         inst_mem_q[wr_ptr_q] <= push_inst_i;
         pc_mem_q[wr_ptr_q]   <= push_pc_i;
      end
   end

   assign head_inst_o = inst_mem_q[rd_ptr_q];
   assign head_pc_o   = pc_mem_q[rd_ptr_q];
   assign count_o     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, in-order memory requests, wrong-path drop and prefetch buffering.
module fetch_unit
   import core_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst,
   fetch_unit_if.master      imem,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              stall,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_valid
);

   localparam int unsigned CntW  = $clog2(DEPTH + 1);
   // Stale responses can pile up across back-to-back redirects with slow memory.
   localparam int unsigned DropW = CntW + 3;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CntW-1:0]   out_q, out_d;
   logic [DropW-1:0]  drop_q, drop_d;

   logic [CntW-1:0]   fifo_count;
   logic [INST_W-1:0] head_inst;
   logic [ADDR_W-1:0] head_pc;
   logic [CntW:0]     inflight;
   logic [ADDR_W-1:0] resp_pc;
   logic              req_fire, drop_hit, resp_ok, push, pop;

   // Request issue, response classification and output presentation.
   always_comb begin
      inflight       = {1'b0, fifo_count} + {1'b0, out_q};
      imem.imem_req  = !rst && !redirect && (inflight < DEPTH[CntW:0]);
      imem.imem_addr = pc_q;
      req_fire       = imem.imem_req && imem.imem_ready;
      // Older (wrong-path) responses return first, so they are consumed before useful ones.
      drop_hit       = imem.imem_rvalid && (drop_q != '0);
      resp_ok        = imem.imem_rvalid && (drop_q == '0) && (out_q != '0);
      // Oldest useful request: pc_q has already advanced past every issued address.
      resp_pc        = pc_q - ADDR_W'(out_q);
      push           = resp_ok && !redirect;
      inst_valid     = (fifo_count != '0);
      pop            = inst_valid && !stall && !redirect;
      inst           = inst_valid ? head_inst : INST_BUBBLE;
      inst_pc        = inst_valid ? head_pc : '0;
   end

   // PC, in-flight and drop counter next-state; a redirect hands all in-flight work to drop.
   always_comb begin
      pc_d   = pc_q;
      out_d  = out_q;
      drop_d = drop_q;
      if (redirect) begin
         pc_d   = redirect_pc;
         out_d  = '0;
         drop_d = drop_q + DropW'(out_q) - DropW'(drop_hit || resp_ok);
      end else begin
         if (req_fire) pc_d = pc_q + 1'b1;
         out_d  = out_q + CntW'(req_fire) - CntW'(resp_ok);
         drop_d = drop_q - DropW'(drop_hit);
      end
   end

   // Fetch state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         out_q  <= '0;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         out_q  <= out_d;
         drop_q <= drop_d;
      end
   end

   fetch_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (redirect),
      .push_i      (push),
      .push_inst_i (imem.imem_rdata),
      .push_pc_i   (resp_pc),
      .pop_i       (pop),
      .head_inst_o (head_inst),
      .head_pc_o   (head_pc),
      .count_o     (fifo_count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: random-latency in-order memory, program-order reference stream.
module tb_fetch_unit;
   import core_pkg::*;

   localparam int unsigned AW  = 16;
   localparam int unsigned WIN = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          redirect = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          stall = 1'b0;
   logic [15:0]   inst;
   logic [AW-1:0] inst_pc;
   logic          inst_valid;

   fetch_unit_if #(.ADDR_W(AW)) imem ();

   fetch_unit #(
      .ADDR_W   (AW),
      .RESET_PC (16'h0000),
      .DEPTH    (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem        (imem),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_valid  (inst_valid)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int n_consumed = 0;

   // Expected program-order PCs still to be consumed (sliding window).
   logic [AW-1:0] exp_q[$];
   // Memory model: accepted addresses and the cycle their response is due.
   logic [AW-1:0] pend_addr[$];
   int            pend_due[$];

   int ready_pct = 100, stall_pct = 0, lat_min = 1, lat_max = 1, redir_pm = 0;
   bit force_stall = 0, force_redir = 0, coincide_arm = 0, coincide_seen = 0;
   bit stray_now = 0, release_now = 0, flush_chk = 0;
   logic [AW-1:0] force_tgt = '0;

   function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
      return a + 16'h1000;
   endfunction

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void reload(input logic [AW-1:0] tgt);
      exp_q.delete();
      for (int i = 0; i < int'(WIN); i++) exp_q.push_back(tgt + AW'(i));
   endfunction

   // One clock cycle of stimulus: memory response, ready, stall, redirect, handshake capture.
   task automatic step();
      bit            r;
      logic [AW-1:0] tgt;
      @(negedge clk);
      if (release_now) begin
         rst = 1'b0;
         release_now = 0;
      end
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata  = '0;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         imem.imem_rvalid = 1'b1;
         imem.imem_rdata  = mem_word(pend_addr[0]);
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else if (stray_now) begin
         imem.imem_rvalid = 1'b1;
         imem.imem_rdata  = 16'hDEAD;
      end
      stray_now = 0;
      imem.imem_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
      stall = force_stall || ($urandom_range(99) < stall_pct);
      r = 0;
      tgt = '0;
      if (force_redir) begin
         r = 1;
         tgt = force_tgt;
         force_redir = 0;
      end else if (coincide_arm && imem.imem_rvalid && !rst) begin
         r = 1;
         tgt = force_tgt;
         stall = 1'b1;
         coincide_arm = 0;
         coincide_seen = 1;
      end else if ($urandom_range(999) < redir_pm) begin
         r = 1;
         tgt = AW'($urandom);
      end
      redirect    = r;
      redirect_pc = tgt;
      #1;
      if (!rst && imem.imem_req && imem.imem_ready) begin
         pend_addr.push_back(imem.imem_addr);
         pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      end
      #2;
      if (r) begin
         reload(tgt);
         flush_chk = 1;
      end
      cyc++;
   endtask

   task automatic wait_consumed(input int n, input int budget, input string name);
      int target;
      target = n_consumed + n;
      for (int i = 0; i < budget && n_consumed < target; i++) step();
      check(name, 32'(n_consumed >= target), 32'd1);
   endtask

   task automatic wait_pending2(input string name);
      for (int i = 0; i < 30 && pend_addr.size() != 2; i++) step();
      check(name, pend_addr.size(), 32'd2);
   endtask

   // Assert reset, check reset outputs, offer stray responses, release and check first fetch.
   task automatic reset_and_release();
      @(negedge clk);
      rst = 1'b1;
      redirect = 1'b0;
      stall = 1'b0;
      imem.imem_rvalid = 1'b0;
      pend_addr.delete();
      pend_due.delete();
      reload(16'h0000);
      ready_pct = 100; stall_pct = 0; lat_min = 1; lat_max = 1; redir_pm = 0;
      #1;
      check("rst_req", imem.imem_req, 32'd0);
      check("rst_valid", inst_valid, 32'd0);
      check("rst_inst", inst, 32'h0);
      check("rst_inst_pc", inst_pc, 32'h0);
      stray_now = 1;
      step();
      check("rst_req_hold", imem.imem_req, 32'd0);
      check("rst_valid_hold", inst_valid, 32'd0);
      release_now = 1;
      stray_now = 1;
      step();
      check("first_req", imem.imem_req, 32'd1);
      check("first_addr", imem.imem_addr, 32'h0);
      step();
      check("valid_cycle1", inst_valid, 32'd0);
      step();
      check("valid_cycle2", inst_valid, 32'd1);
   endtask

   // Monitor: compares every presented instruction with the head of the reference stream.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            if (flush_chk) begin
               check("flush_valid", inst_valid, 32'd0);
               flush_chk = 0;
            end
            if (inst_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_inst", inst_valid, 32'd0);
               end else begin
                  check("inst_pc", inst_pc, exp_q[0]);
                  check("inst", inst, mem_word(exp_q[0]));
                  if (!stall && !redirect) begin
                     exp_q.push_back(exp_q[exp_q.size() - 1] + 1'b1);
                     void'(exp_q.pop_front());
                     n_consumed++;
                  end
               end
            end else begin
               check("bubble", inst, 32'(INST_BUBBLE));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual timeout required finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      imem.imem_ready  = 1'b0;
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata  = '0;

      // Reset then stream with 1-cycle memory.
      reset_and_release();
      wait_consumed(20, 100, "stream");

      // Stall long enough to fill the FIFO; requests must stop and the head must hold.
      for (int i = 0; i < 5; i++) begin
         force_stall = 1;
         step();
         if (i >= 2) begin
            check("stall_req", imem.imem_req, 32'd0);
            check("stall_valid", inst_valid, 32'd1);
         end
      end
      force_stall = 0;
      wait_consumed(6, 50, "after_stall");

      // Redirect with two fetches in flight on 3-cycle memory.
      lat_min = 3; lat_max = 3;
      wait_pending2("two_outstanding");
      force_tgt = 16'h0040;
      force_redir = 1;
      step();
      wait_consumed(4, 60, "redir_0040");

      // Redirect coincident with a response and a stall.
      lat_min = 2; lat_max = 2;
      force_tgt = 16'h0200;
      coincide_arm = 1;
      for (int i = 0; i < 30 && !coincide_seen; i++) step();
      check("coincide_hit", 32'(coincide_seen), 32'd1);
      coincide_arm = 0;
      wait_consumed(4, 60, "redir_0200");

      // PC wrap-around.
      lat_min = 1; lat_max = 1;
      force_tgt = 16'hFFFE;
      force_redir = 1;
      step();
      wait_consumed(4, 40, "wrap");

      // Randomised traffic.
      ready_pct = 70; stall_pct = 20; lat_min = 1; lat_max = 4; redir_pm = 15;
      for (int i = 0; i < 1500; i++) step();
      ready_pct = 100; stall_pct = 0; redir_pm = 0;
      wait_consumed(5, 200, "random_tail");

      // Reset with two fetches in flight, stray responses afterwards.
      lat_min = 3; lat_max = 3;
      wait_pending2("two_outstanding_rst");
      reset_and_release();
      wait_consumed(8, 60, "post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
